// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults for the UART receive path, plus the pointer-width helper
// used wherever the FIFO pointers and the fill count are sized.
package uart_rx_fifo_pkg;
  localparam int UART_DATA_BITS    = 8;
  localparam int UART_RXFIFO_DEPTH = 16;
  localparam int UART_RXFIFO_AFULL = 12;

  // One extra bit beyond the address so full and empty stay distinguishable.
  function automatic int fifo_ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Receive FIFO storage: DEPTH x DATA_BITS register array with one write port
// and one asynchronous read port. The array contents are never reset.
module uart_rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = UART_RXFIFO_DEPTH
) (
  input  logic                     clk_in,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_BITS-1:0]     wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_BITS-1:0]     rd_data
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART deserializer: rising-edge capture of the
// data-ready strobe into a first-word-fall-through FIFO with level/overrun flags.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int DEPTH        = UART_RXFIFO_DEPTH,
  parameter int AFULL_THRESH = UART_RXFIFO_AFULL
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rx_rdy_in,
  input  logic [DATA_BITS-1:0]   rx_data_in,
  input  logic                   rd_ready_in,
  output logic                   rd_valid_out,
  output logic [DATA_BITS-1:0]   rd_data_out,
  output logic [$clog2(DEPTH):0] count_out,
  output logic                   full_out,
  output logic                   almost_full_out,
  output logic                   overrun_out,
  input  logic                   clr_ovr_in,
  input  logic                   flush_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = fifo_ptr_bits(DEPTH);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic          rdy_q, ovr_q;
  logic          wr_stb, rd_fire, full, wr_acc, ovr_set;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH_C);
  assign wr_stb  = rx_rdy_in & ~rdy_q;
  assign rd_fire = (count != '0) & rd_ready_in & ~flush_in;
  // A read in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_acc  = wr_stb & (~full | rd_fire) & ~flush_in;
  assign ovr_set = wr_stb & full & ~rd_fire & ~flush_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rdy_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovr_q  <= 1'b0;
    end else begin
      rdy_q <= rx_rdy_in;
      if (flush_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc)  wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (ovr_set)         ovr_q <= 1'b1;
      else if (clr_ovr_in) ovr_q <= 1'b0;
    end
  end

  uart_rx_fifo_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk_in  (clk_in),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (rx_data_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data_out)
  );

  assign rd_valid_out    = (count != '0);
  assign count_out       = count;
  assign full_out        = full;
  assign almost_full_out = (count >= AFULL_C);
  assign overrun_out     = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a fixed vector table, hand sequences for fill,
// wrap, flush and reset, then random traffic against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       rx_rdy_in = 1'b0;
  logic [7:0] rx_data_in = 8'h00;
  logic       rd_ready_in = 1'b0;
  logic       clr_ovr_in = 1'b0;
  logic       flush_in = 1'b0;
  logic       rd_valid_out, full_out, almost_full_out, overrun_out;
  logic [7:0] rd_data_out;
  logic [4:0] count_out;

  int checks = 0;
  int failures = 0;

  // Reference model: the FIFO contents as a plain queue.
  logic [7:0] mq[$];
  logic       mprev = 1'b0;
  logic       movr = 1'b0;

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       rdr;
    int         exp_count;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[12];

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx_rdy_in(rx_rdy_in), .rx_data_in(rx_data_in),
    .rd_ready_in(rd_ready_in), .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out),
    .count_out(count_out), .full_out(full_out), .almost_full_out(almost_full_out),
    .overrun_out(overrun_out), .clr_ovr_in(clr_ovr_in), .flush_in(flush_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("valid", {31'd0, rd_valid_out}, {31'd0, mq.size() != 0});
    chk("count", {27'd0, count_out}, mq.size());
    chk("full", {31'd0, full_out}, {31'd0, mq.size() == DEPTH});
    chk("afull", {31'd0, almost_full_out}, {31'd0, mq.size() >= AFULL});
    chk("overrun", {31'd0, overrun_out}, {31'd0, movr});
    if (mq.size() != 0) chk("head", {24'd0, rd_data_out}, {24'd0, mq[0]});
  endtask

  // Drive one cycle of inputs, advance the model by the FIFO rules, then compare.
  task automatic cycle(input logic rdy, input logic [7:0] d, input logic rdr,
                       input logic clr, input logic fl);
    logic stb, fire, was_full;
    rx_rdy_in = rdy; rx_data_in = d; rd_ready_in = rdr; clr_ovr_in = clr; flush_in = fl;
    stb = rdy & ~mprev;
    fire = (mq.size() != 0) && rdr;
    was_full = (mq.size() == DEPTH);
    if (fl) mq.delete();
    else begin
      if (fire) void'(mq.pop_front());
      if (stb && (!was_full || fire)) mq.push_back(d);
    end
    if (stb && was_full && !fire && !fl) movr = 1'b1;
    else if (clr) movr = 1'b0;
    mprev = rdy;
    @(posedge clk_in);
    #1;
    compare_model();
  endtask

  task automatic wr_byte(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, rd_valid_out}, 32'd0);
    chk({tag, "_count"}, {27'd0, count_out}, 32'd0);
    chk({tag, "_full"}, {31'd0, full_out}, 32'd0);
    chk({tag, "_afull"}, {31'd0, almost_full_out}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun_out}, 32'd0);
  endtask

  initial begin
    // Pulse 0xA5 and 0x3C, read once, then hold a level of 0x55 for five cycles.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1, 8'hA5};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1, 8'hA5};
    vecs[2]  = '{1'b1, 8'h3C, 1'b0, 2, 8'hA5};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1, 8'h3C};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 0, 8'h00};
    vecs[5]  = '{1'b1, 8'h55, 1'b0, 1, 8'h55};
    vecs[6]  = '{1'b1, 8'h55, 1'b0, 1, 8'h55};
    vecs[7]  = '{1'b1, 8'h55, 1'b0, 1, 8'h55};
    vecs[8]  = '{1'b1, 8'h55, 1'b0, 1, 8'h55};
    vecs[9]  = '{1'b1, 8'h55, 1'b0, 1, 8'h55};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1, 8'h55};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 0, 8'h00};

    repeat (3) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    check_reset_outputs("post_reset");

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].rdy, vecs[i].data, vecs[i].rdr, 1'b0, 1'b0);
      chk($sformatf("vec%0d_count", i), {27'd0, count_out}, vecs[i].exp_count);
      if (vecs[i].exp_count != 0)
        chk($sformatf("vec%0d_data", i), {24'd0, rd_data_out}, {24'd0, vecs[i].exp_data});
    end

    // Fill to full, watching the almost-full and full thresholds.
    for (int k = 1; k <= DEPTH; k++) begin
      wr_byte(8'(k - 1));
      chk($sformatf("fill%0d_afull", k), {31'd0, almost_full_out}, {31'd0, k >= 12});
      chk($sformatf("fill%0d_full", k), {31'd0, full_out}, {31'd0, k == 16});
    end
    wr_byte(8'hFF);
    chk("ovr_set", {31'd0, overrun_out}, 32'd1);
    chk("ovr_count", {27'd0, count_out}, 32'd16);
    chk("ovr_head", {24'd0, rd_data_out}, 32'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovr_clr", {31'd0, overrun_out}, 32'd0);

    // Full FIFO: write coincident with a read is accepted, then drain across the wrap.
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("coinc_count", {27'd0, count_out}, 32'd16);
    chk("coinc_ovr", {31'd0, overrun_out}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d", i), {24'd0, rd_data_out}, (i < 15) ? i + 1 : 32'h77);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", {31'd0, rd_valid_out}, 32'd0);

    // Set overrun, drain to 3 entries, then flush with a coincident strobe.
    for (int k = 0; k < DEPTH; k++) wr_byte(8'(8'h40 + k));
    wr_byte(8'hEE);
    for (int k = 0; k < 13; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("pre_flush_count", {27'd0, count_out}, 32'd3);
    cycle(1'b1, 8'hAB, 1'b0, 1'b0, 1'b1);
    chk("flush_count", {27'd0, count_out}, 32'd0);
    chk("flush_valid", {31'd0, rd_valid_out}, 32'd0);
    chk("flush_ovr", {31'd0, overrun_out}, 32'd1);
    cycle(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
    chk("flush_no_late_write", {27'd0, count_out}, 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset landing in the middle of a write burst.
    wr_byte(8'h11);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rx_rdy_in = 1'b1; rx_data_in = 8'h33;
    #2 rst_in = 1'b1;
    #1;
    check_reset_outputs("midreset");
    mq.delete(); mprev = 1'b0; movr = 1'b0;
    rx_rdy_in = 1'b0;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    compare_model();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
